reg_word_reader: RTL and testbench
==================================

# reg_word_reader

Read-side companion to the 32-bit write-enabled register bank in the messenger datapath. On a start pulse it fetches a programmed number of 32-bit words from the bank through a combinational read port, one address at a time, and streams each word out as four bytes, MSB first, over a valid/ready byte interface toward the transmit path. It is the only consumer of stored message words. It never writes the bank.

## Interface
- NUM_WORDS, 8: number of words in the register bank; addresses 0..NUM_WORDS-1.
- ADDR_W, 3: address width; must satisfy 2**ADDR_W >= NUM_WORDS.

- clk  input  1  single clock; all state changes on the rising edge.
- res  input  1  asynchronous active-low reset; res=0 forces reset state immediately.
- start  input  1  one-cycle request to begin a read burst; sampled only in IDLE.
- word_count  input  ADDR_W+1  number of words to read; sampled with start; values above NUM_WORDS clamp to NUM_WORDS.
- rd_addr  output  ADDR_W  bank read address.
- rd_data  input  32  bank read data; combinational from rd_addr, valid in the same cycle.
- byte_out  output  8  current byte.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  consumer accepts byte_out this cycle when byte_valid=1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the burst completes.

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE: on start=1, latch clamped word_count into cnt and clear word index widx=0. Go to FETCH if cnt>0, else go to DONE.
- FETCH: drive rd_addr=widx. Latch rd_data into a 32-bit holding register and set the byte index bidx=0. Go to SEND.
- SEND: byte_valid=1 and byte_out=hold[31:24] (left-shift form). A handshake occurs when byte_valid=1 and byte_ready=1. On each handshake:
  - shift hold left by 8 and increment bidx.
  - after bidx=3, increment widx. If widx+1==cnt go to DONE, else go to FETCH.
- DONE: assert done for one cycle, then return to IDLE.
- start is ignored in every state other than IDLE. word_count is ignored outside the start cycle.
- rd_addr holds widx in all states; it is 0 in IDLE.
- byte_out and byte_valid must stay stable until the handshake. Changing byte_ready never changes byte_out.
- Arithmetic: widx and cnt are ADDR_W+1 bits wide, so widx never wraps before cnt is reached. bidx is 2 bits wide.

## Timing
- Reset values: rd_addr=0, byte_out=0, byte_valid=0, busy=0, done=0, state=IDLE, hold=0.
- start in cycle 0 gives FETCH in cycle 1 and the first byte_valid=1 in cycle 2.
- With byte_ready held at 1, each word takes 5 cycles (1 FETCH plus 4 SEND). A burst of N words takes 5N+1 cycles from start to the done pulse.
- word_count=0: done pulses in cycle 1 and no byte_valid is ever raised.
- Back-pressure: byte_ready=0 holds the block in SEND indefinitely with no state change.
- Reset during a burst: the block returns to reset values asynchronously. It does not resume, and no done pulse is produced.

## Configuration
- NULL_STOP_EN defined: a handshake on a byte equal to 0x00 ends the burst, and the state goes to DONE regardless of the remaining cnt. The 0x00 byte itself is transferred.
- NULL_STOP_EN undefined: every byte of every requested word is sent, zeros included.

## Structure
- Shared package reg_reader_pkg holds:
  - the state enum (IDLE/FETCH/SEND/DONE)
  - BYTES_PER_WORD=4
  - BYTE_W=8
- One sub-module: word_unpacker. It contains the 32-bit holding register, the load/shift control and the 2-bit bidx counter, and outputs byte_out and a last_byte flag. The FSM and the word counter stay in the top module.

## Test plan
- Reset/idle: hold res=0, then release. Check that all outputs are 0 and busy=0. Pulse start with word_count=0 and check that done pulses in cycle 1 with no byte_valid.
- Single word: bank[0]=0x48656C6C, start with word_count=1 and byte_ready=1. Check bytes 0x48, 0x65, 0x6C, 0x6C in cycles 2-5, then done in cycle 6.
- Back-pressure: same word, byte_ready toggles 1,0,0,1,... Check byte_out stays stable while ready=0, the order is unchanged, and done arrives only after the 4th handshake.
- Clamp/multi-word: NUM_WORDS=8, word_count=15. Check exactly 32 bytes with rd_addr stepping 0..7, and that start pulses mid-burst are ignored.
- NULL_STOP_EN: bank[0]=0x41420043, word_count=2. With the macro, bytes are 0x41, 0x42, 0x00, then done. Without it, all 8 bytes are sent.
- Reset mid-burst: assert res=0 during the 2nd byte. Check outputs drop to 0 immediately, no done, and that a new start afterwards restarts at address 0.

Source files
------------

// File: rtl/reg_reader_pkg.sv
// rtl/reg_reader_pkg.sv - shared state encoding and byte/word geometry for reg_word_reader
package reg_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - holding register that serialises one word MSB-first, with byte index
module word_unpacker
  import reg_reader_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              load,
  input  logic              shift,
  input  logic              clr,
  input  logic [WORD_W-1:0] din,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last_byte
);

  logic [WORD_W-1:0] hold;
  logic [BIDX_W-1:0] bidx;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hold <= '0;
      bidx <= '0;
    end else if (clr) begin
      hold <= '0;
      bidx <= '0;
    end else if (load) begin
      hold <= din;
      bidx <= '0;
    end else if (shift) begin
      hold <= {hold[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      bidx <= bidx + 1'b1;
    end
  end

  // byte_out comes straight from the register, so it cannot follow byte_ready
  assign byte_out  = hold[WORD_W-1 -: BYTE_W];
  assign last_byte = (bidx == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/reg_word_reader.sv
// rtl/reg_word_reader.sv - burst reader of the register bank, streaming words as MSB-first bytes
// Optional: define NULL_STOP_EN to end a burst after transferring a 0x00 byte.
module reg_word_reader
  import reg_reader_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 3
)
(
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_WORDS);

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] widx;
  logic [ADDR_W:0] widx_nxt;
  logic [ADDR_W:0] start_cnt;
  logic            hs;
  logic            last_byte;
  logic            null_hit;
  logic            burst_end;

  assign start_cnt = (word_count > MAX_CNT) ? MAX_CNT : word_count;
  assign widx_nxt  = widx + {{ADDR_W{1'b0}}, 1'b1};
  assign hs        = byte_valid && byte_ready;
  assign rd_addr   = widx[ADDR_W-1:0];

`ifdef NULL_STOP_EN
  assign null_hit = (byte_out == '0);
`else
  assign null_hit = 1'b0;
`endif

  assign burst_end = null_hit || (last_byte && (widx_nxt == cnt));

  word_unpacker u_unpacker (
    .clk       (clk),
    .res       (res),
    .load      (state == FETCH),
    .shift     ((state == SEND) && hs),
    .clr       (state == DONE),
    .din       (rd_data),
    .byte_out  (byte_out),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      cnt        <= '0;
      widx       <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= start_cnt;
            widx <= '0;
            busy <= 1'b1;
            if (start_cnt != '0) begin
              state <= FETCH;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FETCH: begin
          state      <= SEND;
          byte_valid <= 1'b1;
        end
        SEND: begin
          if (hs) begin
            if (last_byte) widx <= widx_nxt;
            if (burst_end) begin
              state      <= DONE;
              done       <= 1'b1;
              byte_valid <= 1'b0;
            end else if (last_byte) begin
              state      <= FETCH;
              byte_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          // widx cleared here so rd_addr reads 0 again once back in IDLE
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          widx  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_word_reader.sv
// tb/tb_reg_word_reader.sv - randomized self-checking bench for reg_word_reader against a byte-queue model
module tb_reg_word_reader;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  word_count = '0;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] bank [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data = bank[rd_addr];

  reg_word_reader #(.NUM_WORDS(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .word_count (word_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Reference: the requested words, clamped to the bank size, as a flat MSB-first byte list
  task automatic build_expected(input int wc, output logic [7:0] q[$]);
    int  n;
    bit  stop;
    logic [31:0] w;
    q.delete();
    n = (wc > 8) ? 8 : wc;
    stop = 0;
    for (int i = 0; i < n && !stop; i++) begin
      w = bank[i];
      for (int b = 0; b < 4 && !stop; b++) begin
        q.push_back(w[31 - 8*b -: 8]);
`ifdef NULL_STOP_EN
        if (w[31 - 8*b -: 8] == 8'h00) stop = 1;
`endif
      end
    end
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_burst(input string tag, input int wc, input int ready_mode, input bit inject);
    logic [7:0] exp_q[$];
    int  total, got, exp_cycle, cyc;
    bit  prev_valid, prev_hs, finished;
    logic [7:0] prev_byte;
    logic r;
    build_expected(wc, exp_q);
    total = exp_q.size();
    exp_cycle = (total == 0) ? 1 : total + (total + 3) / 4 + 1;
    got = 0;
    prev_valid = 0;
    prev_hs = 0;
    prev_byte = '0;
    finished = 0;
    @(negedge clk);
    start = 1'b1;
    word_count = 4'(wc);
    byte_ready = 1'b0;
    for (cyc = 1; cyc <= 2000 && !finished; cyc++) begin
      @(negedge clk);
      if (inject && (cyc % 7 == 3)) begin
        start = 1'b1;
        word_count = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      case (ready_mode)
        0: r = 1'b1;
        1: r = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      byte_ready = r;
      if (prev_valid && !prev_hs) begin
        check({tag, "_hold_valid"}, 32'(byte_valid), 32'd1);
        check({tag, "_hold_byte"}, 32'(byte_out), 32'(prev_byte));
      end
      if (!done) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (byte_valid && r) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_byte"}, 32'(byte_out), 32'hFFFF_FFFF);
        end else begin
          check({tag, "_byte"}, 32'(byte_out), 32'(exp_q.pop_front()));
          check({tag, "_rd_addr"}, 32'(rd_addr), 32'(got / 4));
          got++;
        end
      end
      prev_valid = byte_valid;
      prev_hs = byte_valid && r;
      prev_byte = byte_out;
      if (done) begin
        finished = 1;
        start = 1'b0;
        byte_ready = 1'b0;
        check({tag, "_count"}, 32'(got), 32'(total));
        check({tag, "_valid_at_done"}, 32'(byte_valid), 32'd0);
        if (ready_mode == 0) check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cycle));
      end
    end
    if (!finished) begin
      start = 1'b0;
      byte_ready = 1'b0;
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end
    @(negedge clk);
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = $urandom;

    // reset and idle
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    res = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    run_burst("zero", 0, 0, 0);

    bank[0] = 32'h4865_6C6C;
    run_burst("single", 1, 0, 0);
    run_burst("backpressure", 1, 1, 0);

    run_burst("clamp", 15, 0, 1);
    run_burst("exact8", 8, 1, 0);

    bank[0] = 32'h4142_0043;
    bank[1] = 32'h4445_4647;
    run_burst("nullword", 2, 0, 0);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) begin
        bank[i] = $urandom;
        if ($urandom_range(0, 3) == 0) bank[i][7:0] = 8'h00;
      end
      run_burst("random", $urandom_range(0, 15), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a burst, during the second byte
    for (int i = 0; i < 8; i++) bank[i] = $urandom | 32'h0101_0101;
    @(negedge clk);
    start = 1'b1;
    word_count = 4'd3;
    byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst_first_byte", 32'(byte_out), 32'(bank[0][31:24]));
    @(negedge clk);
    check("midrst_second_valid", 32'(byte_valid), 32'd1);
    #2 res = 1'b0;
    #1 check_idle_outputs("midrst_async");
    repeat (2) @(negedge clk);
    res = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
      check("midrst_no_busy", 32'(busy), 32'd0);
    end
    byte_ready = 1'b0;
    run_burst("restart", 3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
